// File: rtl/linreg_pkg.sv
// Shared types, constants and helpers for the linear-regression datapath.
// sat32 is used by grad_theta_update when GRAD_SAT_EN is defined.
package linreg_pkg;

   localparam int DATA_W   = 32;
   localparam int FRAC_DEF = 16;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_MAC  = 2'd1;
   localparam logic [1:0] ST_UPD  = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   localparam logic signed [63:0] MAX32 = 64'sd2147483647;
   localparam logic signed [63:0] MIN32 = -64'sd2147483648;

   function automatic logic signed [DATA_W-1:0] sat32(input logic signed [63:0] v);
      logic signed [DATA_W-1:0] res;
      if (v > MAX32)
         res = 32'sh7FFF_FFFF;
      else if (v < MIN32)
         res = 32'sh8000_0000;
      else
         res = $signed(v[DATA_W-1:0]);
      return res;
   endfunction

endpackage

// File: rtl/grad_mac.sv
// Signed 32x32 multiply, arithmetic shift by FRAC, and accumulate.
// Synchronous clear has priority over enable.
module grad_mac
   import linreg_pkg::*;
#(
   parameter int FRAC  = FRAC_DEF,
   parameter int ACC_W = 38
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    clr,
   input  logic                    en,
   input  logic signed [DATA_W-1:0] a,
   input  logic signed [DATA_W-1:0] b,
   output logic signed [ACC_W-1:0]  acc
);

   logic signed [2*DATA_W-1:0] prod;
   logic signed [ACC_W-1:0]    term;

   always_comb begin
      prod = a * b;
      term = ACC_W'(prod >>> FRAC);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         acc <= '0;
      else if (clr)
         acc <= '0;
      else if (en)
         acc <= acc + term;
   end

endmodule

// File: rtl/grad_theta_update.sv
// One gradient-descent step: theta_new[j] = theta[j] - ((sum_i X[i][j]*r[i]) >>> ALPHA_SHIFT).
// Define GRAD_SAT_EN to saturate the update to 32 bits instead of wrapping.
module grad_theta_update
   import linreg_pkg::*;
#(
   parameter int m           = 20,
   parameter int n           = 4,
   parameter int FRAC        = FRAC_DEF,
   parameter int ALPHA_SHIFT = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic [DATA_W*m-1:0]       Xtheta_Y,
   input  logic [DATA_W*m*n-1:0]     X,
   input  logic [DATA_W*n-1:0]       theta_in,
   output logic                      busy,
   output logic                      done,
   output logic [DATA_W*n-1:0]       theta_out
);

   localparam int ACC_W = DATA_W + $clog2(m) + 1;
   localparam int IW    = (m > 1) ? $clog2(m) : 1;
   localparam int JW    = (n > 1) ? $clog2(n) : 1;

   logic [1:0]    state;
   logic [IW-1:0] i;
   logic [JW-1:0] j;

   logic signed [DATA_W-1:0] r_mem     [m];
   logic signed [DATA_W-1:0] x_mem     [m][n];
   logic signed [DATA_W-1:0] theta_reg [n];

   logic signed [ACC_W-1:0]  acc;
   logic signed [ACC_W-1:0]  step;
   logic signed [DATA_W-1:0] upd_val;
   logic [DATA_W*n-1:0]      theta_next;
   logic                     accept;
   logic                     mac_clr;
   logic                     mac_en;

   assign accept  = (state == ST_IDLE) && start;
   assign mac_clr = accept || (state == ST_UPD);
   assign mac_en  = (state == ST_MAC);
   assign busy    = (state != ST_IDLE);
   assign done    = (state == ST_DONE);

   grad_mac #(
      .FRAC  (FRAC),
      .ACC_W (ACC_W)
   ) u_mac (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (mac_clr),
      .en    (mac_en),
      .a     (x_mem[i][j]),
      .b     (r_mem[i]),
      .acc   (acc)
   );

`ifdef GRAD_SAT_EN
   logic signed [63:0]       step64;
   logic signed [DATA_W-1:0] step_c;
   logic signed [63:0]       diff64;

   always_comb begin
      step    = acc >>> ALPHA_SHIFT;
      step64  = $signed({{(64-ACC_W){step[ACC_W-1]}}, step});
      step_c  = sat32(step64);
      diff64  = $signed({{32{theta_reg[j][DATA_W-1]}}, theta_reg[j]})
              - $signed({{32{step_c[DATA_W-1]}}, step_c});
      upd_val = sat32(diff64);
   end
`else
   always_comb begin
      step    = acc >>> ALPHA_SHIFT;
      upd_val = theta_reg[j] - DATA_W'(step);
   end
`endif

   always_comb begin
      theta_next = '0;
      for (int unsigned k = 0; k < n; k++)
         theta_next[DATA_W*n-1-DATA_W*k -: DATA_W] = (32'(j) == k) ? upd_val : theta_reg[k];
   end

   // Data copies need no reset: they are always loaded on accept before use.
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int unsigned k = 0; k < m; k++)
            r_mem[k] <= $signed(Xtheta_Y[DATA_W*m-1-DATA_W*k -: DATA_W]);
         for (int unsigned k = 0; k < m; k++)
            for (int unsigned l = 0; l < n; l++)
               x_mem[k][l] <= $signed(X[DATA_W*m*n-1-DATA_W*(k*n+l) -: DATA_W]);
         for (int unsigned k = 0; k < n; k++)
            theta_reg[k] <= $signed(theta_in[DATA_W*n-1-DATA_W*k -: DATA_W]);
      end else if (state == ST_UPD) begin
         theta_reg[j] <= upd_val;
      end
   end

   // theta_out is loaded on entry to DONE so it is already valid while done is high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         i         <= '0;
         j         <= '0;
         theta_out <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state <= ST_MAC;
                  i     <= '0;
                  j     <= '0;
               end
            end
            ST_MAC: begin
               if (i == IW'(m - 1))
                  state <= ST_UPD;
               else
                  i <= i + 1'b1;
            end
            ST_UPD: begin
               i <= '0;
               if (j == JW'(n - 1)) begin
                  state     <= ST_DONE;
                  theta_out <= theta_next;
               end else begin
                  j     <= j + 1'b1;
                  state <= ST_MAC;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_grad_theta_update.sv
// Table-driven, scoreboard-checked bench for grad_theta_update (m=20, n=4).
// Expected overflow results follow GRAD_SAT_EN when it is defined for the build.
module tb_grad_theta_update;

   localparam int M = 20;
   localparam int N = 4;
   localparam int LAT = N * (M + 1) + 1;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start;
   logic [32*M-1:0]   r_in;
   logic [32*M*N-1:0] x_in;
   logic [32*N-1:0]   th_in;
   logic              busy;
   logic              done;
   logic [32*N-1:0]   th_out;

   int n_cmp = 0;
   int n_bad = 0;
   logic [32*N-1:0] sb[$];

   typedef struct {
      logic [32*M-1:0]   r;
      logic [32*M*N-1:0] x;
      logic [32*N-1:0]   th;
      logic [32*N-1:0]   exp;
   } vec_t;

   vec_t tbl[4];

   always #5 clk = ~clk;

   grad_theta_update #(
      .m           (M),
      .n           (N),
      .FRAC        (16),
      .ALPHA_SHIFT (8)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .Xtheta_Y  (r_in),
      .X         (x_in),
      .theta_in  (th_in),
      .busy      (busy),
      .done      (done),
      .theta_out (th_out)
   );

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic int xo(int i, int j);
      return 32*M*N - 1 - 32*(i*N + j);
   endfunction

   function automatic int ro(int i);
      return 32*M - 1 - 32*i;
   endfunction

   function automatic int to(int j);
      return 32*N - 1 - 32*j;
   endfunction

   // Reference: plain 64-bit arithmetic on the unpacked values.
   function automatic logic [32*N-1:0] model(logic [32*M-1:0] r, logic [32*M*N-1:0] x,
                                             logic [32*N-1:0] th);
      logic [32*N-1:0] res;
      longint g, xv, rv, t;
      res = '0;
      for (int j = 0; j < N; j++) begin
         g = 0;
         for (int i = 0; i < M; i++) begin
            xv = longint'($signed(x[xo(i, j) -: 32]));
            rv = longint'($signed(r[ro(i) -: 32]));
            g += (xv * rv) >>> 16;
         end
         t = longint'($signed(th[to(j) -: 32])) - (g >>> 8);
`ifdef GRAD_SAT_EN
         if (t > 64'sd2147483647) t = 64'sd2147483647;
         if (t < -64'sd2147483648) t = -64'sd2147483648;
`endif
         res[to(j) -: 32] = t[31:0];
      end
      return res;
   endfunction

   // Scoreboard: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst_n && done) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_done: got done=1 expected no pending iteration");
         end else begin
            logic [32*N-1:0] e;
            e = sb.pop_front();
            check("theta_out", th_out, e);
         end
      end
   end

   task automatic scramble();
      for (int k = 0; k < M*N; k++) x_in[32*k +: 32] = $urandom();
      for (int k = 0; k < M; k++)   r_in[32*k +: 32] = $urandom();
      for (int k = 0; k < N; k++)   th_in[32*k +: 32] = $urandom();
   endtask

   task automatic wait_done(output int cyc);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!done && cyc < 300);
      if (!done) check("done_timeout", done, 1'b1);
   endtask

   task automatic run_iter(input vec_t v, input string tag);
      int lat;
      @(negedge clk);
      r_in  = v.r;
      x_in  = v.x;
      th_in = v.th;
      start = 1'b1;
      @(posedge clk);
      #1;
      sb.push_back(v.exp);
      start = 1'b0;
      check({tag, "_busy_after_accept"}, busy, 1'b1);
      scramble();
      wait_done(lat);
      check({tag, "_latency"}, lat, LAT);
      @(negedge clk);
      check({tag, "_busy_after_done"}, busy, 1'b0);
      check({tag, "_theta_held"}, th_out, v.exp);
   endtask

   initial begin
      logic [32*M-1:0]   rt;
      logic [32*M*N-1:0] xt;
      logic [32*N-1:0]   tt;
      logic [32*N-1:0]   et;
      int lat, per, low, dn;

      rst_n = 1'b0;
      start = 1'b0;
      r_in  = '0;
      x_in  = '0;
      th_in = '0;
      repeat (3) @(negedge clk);
      check("reset_busy", busy, 1'b0);
      check("reset_done", done, 1'b0);
      check("reset_theta", th_out, '0);
      rst_n = 1'b1;

      // Residual zero: theta passes through unchanged.
      rt = '0;
      for (int k = 0; k < M*N; k++) xt[32*k +: 32] = $urandom();
      tt = {32'h0001_0000, 32'h0002_0000, 32'hFFFF_0000, 32'h0000_0000};
      tbl[0].r = rt; tbl[0].x = xt; tbl[0].th = tt; tbl[0].exp = tt;

      // g0 = 20.0 -> theta0 = -(20.0 >>> 8) = -0x1400.
      rt = '0; xt = '0;
      for (int i = 0; i < M; i++) begin
         rt[ro(i) -: 32] = 32'h0001_0000;
         xt[xo(i, 0) -: 32] = 32'h0001_0000;
      end
      tbl[1].r = rt; tbl[1].x = xt; tbl[1].th = '0;
      tbl[1].exp = {32'hFFFF_EC00, 96'h0};

      // g0 = -5120.0 -> step = -0x140000, theta0 overflows past 0x7FFFFFFF.
      rt = '0; xt = '0;
      for (int i = 0; i < M; i++) begin
         rt[ro(i) -: 32] = 32'hFFF0_0000;
         xt[xo(i, 0) -: 32] = 32'h0010_0000;
      end
      tt = {32'h7FFF_0000, 32'h0001_0000, 32'h0000_0000, 32'hFFFF_8000};
`ifdef GRAD_SAT_EN
      et = {32'h7FFF_FFFF, 32'h0001_0000, 32'h0000_0000, 32'hFFFF_8000};
`else
      et = {32'h8013_0000, 32'h0001_0000, 32'h0000_0000, 32'hFFFF_8000};
`endif
      tbl[2].r = rt; tbl[2].x = xt; tbl[2].th = tt; tbl[2].exp = et;

      // Mixed-sign random data, sized so the accumulator cannot overflow.
      for (int i = 0; i < M; i++) begin
         rt[ro(i) -: 32] = 32'(int'($urandom_range(0, 2097151)) - 1048576);
         for (int j = 0; j < N; j++)
            xt[xo(i, j) -: 32] = 32'(int'($urandom_range(0, 2097151)) - 1048576);
      end
      for (int j = 0; j < N; j++)
         tt[to(j) -: 32] = 32'(int'($urandom_range(0, 32'h7FFF_FFFF)) - 32'sh4000_0000);
      tbl[3].r = rt; tbl[3].x = xt; tbl[3].th = tt; tbl[3].exp = model(rt, xt, tt);

      for (int k = 0; k < 4; k++)
         run_iter(tbl[k], $sformatf("vec%0d", k));

      // Reset during MAC: abort without done, theta_out cleared.
      @(negedge clk);
      r_in = tbl[3].r; x_in = tbl[3].x; th_in = tbl[3].th;
      start = 1'b1;
      @(posedge clk);
      #1;
      sb.push_back(tbl[3].exp);
      start = 1'b0;
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      #1;
      sb.delete();
      check("abort_busy", busy, 1'b0);
      check("abort_done", done, 1'b0);
      check("abort_theta", th_out, '0);
      @(negedge clk);
      rst_n = 1'b1;
      dn = 0;
      repeat (100) begin
         @(negedge clk);
         if (done || busy) dn++;
      end
      check("abort_quiet", dn, 0);
      run_iter(tbl[1], "post_abort");

      // start held high: back-to-back iterations, one idle cycle between.
      @(negedge clk);
      r_in = tbl[3].r; x_in = tbl[3].x; th_in = tbl[3].th;
      start = 1'b1;
      @(posedge clk);
      #1;
      sb.push_back(tbl[3].exp);
      sb.push_back(tbl[3].exp);
      wait_done(lat);
      check("b2b_latency", lat, LAT);
      per = 0;
      low = 0;
      do begin
         @(negedge clk);
         per++;
         if (!busy) low++;
      end while (!done && per < 300);
      start = 1'b0;
      check("b2b_period", per, LAT + 1);
      check("b2b_idle_cycles", low, 1);
      repeat (2) @(negedge clk);
      check("b2b_stopped", busy, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no completion expected finish before 1ms");
      $fatal(1, "watchdog expired");
   end

endmodule
